// File: rtl/axis_seq_checker_pkg.sv
// rtl/axis_seq_checker_pkg.sv - shared FSM encodings and LFSR constants for the sequence checker
package axis_seq_checker_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of an 8-bit register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] q);
        lfsr8_step = {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_seq_checker_lfsr8.sv
// rtl/axis_seq_checker_lfsr8.sv - 8-bit Fibonacci LFSR with synchronous seed load
module lfsr8
    import axis_seq_checker_pkg::*;
#(
    parameter logic [7:0] c_RESET_VALUE = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // Load wins over advance so a clear always restarts the pattern from the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= c_RESET_VALUE;
        end else if (load) begin
            r_q <= seed;
        end else if (advance) begin
            r_q <= lfsr8_step(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/axis_seq_checker.sv
// rtl/axis_seq_checker.sv - AXI-Stream sink checking an incrementing data sequence with optional LFSR backpressure
module axis_seq_checker
    import axis_seq_checker_pkg::*;
#(
    parameter int         c_WIDTH     = 8,
    parameter int         c_CNT_WIDTH = 16,
    parameter logic [7:0] c_LFSR_SEED = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   throttle,
    input  logic                   clear,
    input  logic [c_WIDTH-1:0]     s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic                   locked,
    output logic [c_CNT_WIDTH-1:0] beat_count,
    output logic [c_CNT_WIDTH-1:0] err_count,
    output logic                   err_flag,
    output logic [c_WIDTH-1:0]     first_err_exp,
    output logic [c_WIDTH-1:0]     first_err_got
);

    localparam logic [c_WIDTH-1:0]     lp_DATA_ONE = {{(c_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_WIDTH-1:0] lp_CNT_ONE  = {{(c_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [c_WIDTH-1:0]     r_expected;
    logic                   r_tready;
    logic                   r_locked;
    logic [c_CNT_WIDTH-1:0] r_beat_count;
    logic [c_CNT_WIDTH-1:0] r_err_count;
    logic                   r_err_flag;
    logic [c_WIDTH-1:0]     r_first_err_exp;
    logic [c_WIDTH-1:0]     r_first_err_got;

    logic                   w_running;
    logic                   w_accept;
    logic                   w_sync_beat;
    logic                   w_check_beat;
    logic                   w_mismatch;
    logic [c_WIDTH-1:0]     w_data_next;
    logic [c_CNT_WIDTH-1:0] w_beat_inc;
    logic [c_CNT_WIDTH-1:0] w_err_inc;
    logic [7:0]             w_lfsr_q;
    logic [7:0]             w_lfsr_next;
    logic                   w_tready_next;

    assign w_running    = (r_state == ST_SYNC) || (r_state == ST_CHECK);
    assign w_accept     = s_axis_tvalid && r_tready;
    assign w_sync_beat  = w_accept && (r_state == ST_SYNC);
    assign w_check_beat = w_accept && (r_state == ST_CHECK);
    assign w_mismatch   = w_check_beat && (s_axis_tdata != r_expected);
    assign w_data_next  = s_axis_tdata + lp_DATA_ONE;

    // Counters stick at all-ones instead of wrapping
    assign w_beat_inc = (&r_beat_count) ? r_beat_count : r_beat_count + lp_CNT_ONE;
    assign w_err_inc  = (&r_err_count)  ? r_err_count  : r_err_count  + lp_CNT_ONE;

    lfsr8 #(
        .c_RESET_VALUE (c_LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (clear),
        .advance (w_running),
        .seed    (c_LFSR_SEED),
        .q       (w_lfsr_q)
    );

    assign w_lfsr_next   = lfsr8_step(w_lfsr_q);
    assign w_tready_next = enable && (r_state != ST_IDLE) && (!throttle || w_lfsr_next[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= w_tready_next;
        end
    end

    // FSM; dropping enable aborts the lock even if a beat lands on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (clear) begin
            r_state <= enable ? ST_SYNC : ST_IDLE;
        end else if (!enable) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_SYNC;
                ST_SYNC:  if (w_accept) r_state <= ST_CHECK;
                ST_CHECK: r_state <= ST_CHECK;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected <= '0;
        end else if (!clear && (w_sync_beat || w_check_beat)) begin
            r_expected <= w_data_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (clear || !enable) begin
            r_locked <= 1'b0;
        end else if (w_sync_beat) begin
            r_locked <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_count <= '0;
            r_err_count  <= '0;
        end else if (clear) begin
            r_beat_count <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_sync_beat || w_check_beat) begin
                r_beat_count <= w_beat_inc;
            end
            if (w_mismatch) begin
                r_err_count <= w_err_inc;
            end
        end
    end

    // Only the first mismatch since reset/clear is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_flag      <= 1'b0;
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
        end else if (clear) begin
            r_err_flag      <= 1'b0;
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
        end else if (w_mismatch && !r_err_flag) begin
            r_err_flag      <= 1'b1;
            r_first_err_exp <= r_expected;
            r_first_err_got <= s_axis_tdata;
        end
    end

    assign s_axis_tready = r_tready;
    assign locked        = r_locked;
    assign beat_count    = r_beat_count;
    assign err_count     = r_err_count;
    assign err_flag      = r_err_flag;
    assign first_err_exp = r_first_err_exp;
    assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_axis_seq_checker.sv
// tb/tb_axis_seq_checker.sv - directed self-checking bench for axis_seq_checker
module tb_axis_seq_checker;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        throttle;
    logic        clear;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        locked;
    logic [15:0] beat_count;
    logic [15:0] err_count;
    logic        err_flag;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_got;

    int checks = 0;
    int errors = 0;

    axis_seq_checker #(
        .c_WIDTH     (8),
        .c_CNT_WIDTH (16),
        .c_LFSR_SEED (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .throttle      (throttle),
        .clear         (clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .locked        (locked),
        .beat_count    (beat_count),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        tick();
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Reference LFSR: taps 8,6,5,4 numbered from 1 at the LSB
    function automatic logic [7:0] model_step(input logic [7:0] q);
        logic fb;
        fb = q[8-1] ^ q[6-1] ^ q[5-1] ^ q[4-1];
        return {q[6:0], fb};
    endfunction

    logic [7:0] m_lfsr;
    logic       m_rdy;
    logic [7:0] d;
    int         exp_beats;

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        throttle      = 1'b0;
        clear         = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_tready",   32'(s_axis_tready), 32'd0);
        check("rst_locked",   32'(locked),        32'd0);
        check("rst_beats",    32'(beat_count),    32'd0);
        check("rst_errs",     32'(err_count),     32'd0);
        check("rst_flag",     32'(err_flag),      32'd0);
        check("rst_exp",      32'(first_err_exp), 32'd0);
        check("rst_got",      32'(first_err_got), 32'd0);

        tick();
        check("idle_tready", 32'(s_axis_tready), 32'd0);

        // enable -> tready two edges later
        enable = 1'b1;
        tick();
        check("en_tready_c1", 32'(s_axis_tready), 32'd0);
        tick();
        check("en_tready_c2", 32'(s_axis_tready), 32'd1);
        check("en_unlocked",  32'(locked),        32'd0);

        for (int i = 0; i < 16; i++) send(8'(i));
        idle();
        check("seq_beats",  32'(beat_count), 32'd16);
        check("seq_errs",   32'(err_count),  32'd0);
        check("seq_locked", 32'(locked),     32'd1);
        check("seq_flag",   32'(err_flag),   32'd0);

        // wrap through 0xFF
        pulse_clear();
        send(8'hFD); send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
        idle();
        check("wrap_beats", 32'(beat_count), 32'd5);
        check("wrap_errs",  32'(err_count),  32'd0);

        // dropped beat 0x12
        pulse_clear();
        send(8'h10); send(8'h11); send(8'h13); send(8'h14);
        idle();
        check("drop_beats", 32'(beat_count),    32'd4);
        check("drop_errs",  32'(err_count),     32'd1);
        check("drop_flag",  32'(err_flag),      32'd1);
        check("drop_exp",   32'(first_err_exp), 32'h12);
        check("drop_got",   32'(first_err_got), 32'h13);
        send(8'h20);
        idle();
        check("drop2_errs", 32'(err_count),     32'd2);
        check("drop2_exp",  32'(first_err_exp), 32'h12);
        check("drop2_got",  32'(first_err_got), 32'h13);

        // clear coincident with an accepted beat discards it
        clear         = 1'b1;
        s_axis_tdata  = 8'h40;
        s_axis_tvalid = 1'b1;
        tick();
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
        check("clr_beats",  32'(beat_count),    32'd0);
        check("clr_errs",   32'(err_count),     32'd0);
        check("clr_flag",   32'(err_flag),      32'd0);
        check("clr_locked", 32'(locked),        32'd0);
        check("clr_exp",    32'(first_err_exp), 32'd0);
        check("clr_got",    32'(first_err_got), 32'd0);
        send(8'h41);
        idle();
        check("relock_beats",  32'(beat_count), 32'd1);
        check("relock_errs",   32'(err_count),  32'd0);
        check("relock_locked", 32'(locked),     32'd1);

        // enable drop
        enable = 1'b0;
        tick();
        check("dis_tready", 32'(s_axis_tready), 32'd0);
        check("dis_locked", 32'(locked),        32'd0);
        check("dis_beats",  32'(beat_count),    32'd1);
        enable = 1'b1;
        tick();
        tick();
        check("reen_tready", 32'(s_axis_tready), 32'd1);

        // throttle from a freshly reloaded seed
        throttle = 1'b1;
        pulse_clear();
        s_axis_tvalid = 1'b0;
        tick();
        m_lfsr = model_step(8'hA5);
        m_rdy  = m_lfsr[0];
        check("thr_tready_first", 32'(s_axis_tready), 32'(m_rdy));
        exp_beats = 0;
        d = 8'h60;
        for (int k = 0; k < 40; k++) begin
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            tick();
            if (m_rdy) begin
                exp_beats++;
                d = d + 8'd1;
            end
            m_lfsr = model_step(m_lfsr);
            m_rdy  = m_lfsr[0];
            check("thr_tready", 32'(s_axis_tready), 32'(m_rdy));
            check("thr_beats",  32'(beat_count),    32'(exp_beats));
        end
        s_axis_tvalid = 1'b0;
        throttle      = 1'b0;
        tick();
        check("thr_errs", 32'(err_count), 32'd0);

        // build up three errors, then reset mid-stream
        pulse_clear();
        send(8'h00); send(8'h05); send(8'h0A); send(8'h0F);
        idle();
        check("pre_rst_errs", 32'(err_count), 32'd3);
        s_axis_tdata  = 8'h10;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_tready", 32'(s_axis_tready), 32'd0);
        check("arst_locked", 32'(locked),        32'd0);
        check("arst_beats",  32'(beat_count),    32'd0);
        check("arst_errs",   32'(err_count),     32'd0);
        check("arst_flag",   32'(err_flag),      32'd0);
        check("arst_exp",    32'(first_err_exp), 32'd0);
        check("arst_got",    32'(first_err_got), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_tready_c1", 32'(s_axis_tready), 32'd0);
        tick();
        check("post_rst_tready_c2", 32'(s_axis_tready), 32'd1);
        send(8'h77);
        idle();
        check("post_rst_beats",  32'(beat_count), 32'd1);
        check("post_rst_errs",   32'(err_count),  32'd0);
        check("post_rst_locked", 32'(locked),     32'd1);
        check("post_rst_flag",   32'(err_flag),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
